// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared constants, field-index helpers and operand type for the
//          floating-point add/subtract pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int BIAS       = (1 << (FP32_EXP_W - 1)) - 1;
    localparam int EXP_MAX    = (1 << FP32_EXP_W) - 2;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp_operand_t;

    function automatic int f_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Largest finite biased exponent; all-ones is left to the caller.
    function automatic int f_exp_max(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

    function automatic int f_exp_lsb(input int man_w);
        return man_w;
    endfunction

    function automatic int f_sign_idx(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module : fp_lzc
// Brief  : Parametrised leading-zero counter; all-zero input returns W.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_cnt
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// Module : fp_addsub_pipe
// Brief  : 4-stage floating-point add/subtract with global-stall flow control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_addsub_pipe import fp_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_res,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_ovf
);

    localparam int N   = MAN_W + 4;
    localparam int LZW = $clog2(N + 1);
    localparam int SI  = f_sign_idx(EXP_W, MAN_W);
    localparam int EL  = f_exp_lsb(MAN_W);
    localparam logic signed [EXP_W+1:0] C_EMAX   = (EXP_W+2)'(f_exp_max(EXP_W));
    localparam logic signed [EXP_W+1:0] C_ONE    = 1;
    localparam logic        [EXP_W-1:0] C_EMAX_F = EXP_W'(f_exp_max(EXP_W));

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // S1: unpack, flush zero/denormal mantissas, order by magnitude
    logic               w_a_s, w_b_s, w_swap;
    logic [EXP_W-1:0]   w_a_e, w_b_e;
    logic [MAN_W:0]     w_a_m, w_b_m;

    assign w_a_s  = in_a[SI];
    assign w_b_s  = in_b[SI] ^ in_sub;
    assign w_a_e  = in_a[SI-1:EL];
    assign w_b_e  = in_b[SI-1:EL];
    assign w_a_m  = (|w_a_e) ? {1'b1, in_a[MAN_W-1:0]} : '0;
    assign w_b_m  = (|w_b_e) ? {1'b1, in_b[MAN_W-1:0]} : '0;
    assign w_swap = {w_b_e, w_b_m} > {w_a_e, w_a_m};

    logic               r1_valid, r1_ls, r1_ss;
    logic [EXP_W-1:0]   r1_le, r1_d;
    logic [MAN_W:0]     r1_lm, r1_sm;
    logic [TAG_W-1:0]   r1_tag;

    // S2: align smaller operand, folding shifted-out bits into sticky
    logic [N-1:0]       w_s_ext, w_al;
    logic [2*N-1:0]     w_wide;

    assign w_s_ext = {r1_sm, 3'b000};
    assign w_wide  = {w_s_ext, {N{1'b0}}} >> r1_d;
    assign w_al    = (32'(r1_d) >= N) ? {{(N-1){1'b0}}, |w_s_ext}
                                      : {w_wide[2*N-1:N+1], w_wide[N] | (|w_wide[N-1:0])};

    logic               r2_valid, r2_s, r2_add;
    logic [EXP_W-1:0]   r2_e;
    logic [MAN_W:0]     r2_lm;
    logic [N-1:0]       r2_al;
    logic [TAG_W-1:0]   r2_tag;

    // S3: magnitude add/subtract; larger operand guarantees a non-negative difference
    logic [N:0]         w_l_ext, w_sum;

    assign w_l_ext = {1'b0, r2_lm, 3'b000};
    assign w_sum   = r2_add ? (w_l_ext + {1'b0, r2_al}) : (w_l_ext - {1'b0, r2_al});

    logic               r3_valid, r3_s;
    logic [EXP_W-1:0]   r3_e;
    logic [N:0]         r3_sum;
    logic [TAG_W-1:0]   r3_tag;

    // S4: normalise, truncate, range-check, pack
    logic [LZW-1:0]             w_lzc;
    logic [N-1:0]               w_norm;
    logic signed [EXP_W+1:0]    w_e_base, w_exp_c;
    logic [MAN_W-1:0]           w_frac;
    logic [EXP_W+MAN_W:0]       w_res;
    logic                       w_ovf;
    logic                       w_unused;

    fp_lzc #(.W(N)) u_lzc (
        .i_data (r3_sum[N-1:0]),
        .o_cnt  (w_lzc)
    );

    assign w_norm   = r3_sum[N-1:0] << w_lzc;
    assign w_e_base = $signed({2'b00, r3_e});
    assign w_exp_c  = r3_sum[N] ? (w_e_base + C_ONE)
                                : (w_e_base - $signed({{(EXP_W+2-LZW){1'b0}}, w_lzc}));
    assign w_frac   = r3_sum[N] ? r3_sum[N-1:4] : w_norm[N-2:3];
    assign w_unused = ^{w_norm[N-1], w_norm[2:0]};

    always_comb begin
        w_ovf = 1'b0;
        w_res = {r3_s, w_exp_c[EXP_W-1:0], w_frac};
        if (r3_sum == '0) begin
            w_res = '0;
        end else if (w_exp_c > C_EMAX) begin
            w_res = {r3_s, C_EMAX_F, {MAN_W{1'b1}}};
            w_ovf = 1'b1;
        end else if (w_exp_c < C_ONE) begin
            w_res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r1_ls     <= w_swap ? w_b_s : w_a_s;
            r1_le     <= w_swap ? w_b_e : w_a_e;
            r1_lm     <= w_swap ? w_b_m : w_a_m;
            r1_ss     <= w_swap ? w_a_s : w_b_s;
            r1_sm     <= w_swap ? w_a_m : w_b_m;
            r1_d      <= w_swap ? (w_b_e - w_a_e) : (w_a_e - w_b_e);
            r1_tag    <= in_tag;

            r2_valid  <= r1_valid;
            r2_s      <= r1_ls;
            r2_add    <= (r1_ls == r1_ss);
            r2_e      <= r1_le;
            r2_lm     <= r1_lm;
            r2_al     <= w_al;
            r2_tag    <= r1_tag;

            r3_valid  <= r2_valid;
            r3_s      <= r2_s;
            r3_e      <= r2_e;
            r3_sum    <= w_sum;
            r3_tag    <= r2_tag;

            out_valid <= r3_valid;
            out_res   <= w_res;
            out_tag   <= r3_tag;
            out_ovf   <= r3_valid & w_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// ============================================================================
// Module : tb_fp_addsub_pipe
// Brief  : Directed-vector bench for fp_addsub_pipe (FP32 configuration).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [3:0]  out_tag;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic        ovf;
    } vec_t;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

    // Drives one operation into an empty pipe and waits (bounded) for its result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] t, output logic [31:0] r,
                          output logic [3:0] rt, output logic ov, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = out_res; rt = out_tag; ov = out_ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++;
        if (out_res !== 32'h0) begin failures++; $display("FAIL reset_res: got %h required 00000000", out_res); end
        checks++;
        if (out_tag !== 4'h0 || out_ovf !== 1'b0) begin
            failures++; $display("FAIL reset_tag_ovf: got tag=%h ovf=%b required tag=0 ovf=0", out_tag, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [3:0] rt; logic ov; int lat;
        run_op(32'h40400000, 32'h3F800000, 1'b1, 4'hA, r, rt, ov, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL basic_latency: got %0d required 4", lat); end
        checks++;
        if (r !== 32'h40000000) begin failures++; $display("FAIL basic_res: got %h required 40000000", r); end
        checks++;
        if (rt !== 4'hA || ov !== 1'b0) begin
            failures++; $display("FAIL basic_tag_ovf: got tag=%h ovf=%b required tag=a ovf=0", rt, ov);
        end
    endtask

    task automatic test_special_values();
        vec_t v[9];
        logic [31:0] r; logic [3:0] rt; logic ov; int lat;
        v[0] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0}; // cancellation
        v[1] = '{32'h40200000, 32'h40400000, 1'b1, 32'hBF000000, 1'b0}; // sign flip
        v[2] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0}; // far align
        v[3] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 1'b0}; // truncation
        v[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b1}; // +overflow
        v[5] = '{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0}; // zero operand
        v[6] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0}; // underflow
        v[7] = '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF7FFFFF, 1'b1}; // -overflow
        v[8] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0}; // denormal flush
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].a, v[i].b, v[i].sub, 4'(i), r, rt, ov, lat);
            checks++;
            if (r !== v[i].r) begin
                failures++; $display("FAIL special_res[%0d]: got %h required %h", i, r, v[i].r);
            end
            checks++;
            if (ov !== v[i].ovf) begin
                failures++; $display("FAIL special_ovf[%0d]: got %b required %b", i, ov, v[i].ovf);
            end
            checks++;
            if (rt !== 4'(i) || lat !== 4) begin
                failures++; $display("FAIL special_tag_lat[%0d]: got tag=%h lat=%0d required tag=%h lat=4", i, rt, lat, 4'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[8];
        int sent = 0, rcvd = 0, cyc = 0;
        logic stall = 1'b0, ofire, ifire;
        logic [31:0] hres = '0;
        logic [3:0]  htag = '0;
        v[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
        v[1] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0};
        v[2] = '{32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 1'b0};
        v[3] = '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0};
        v[4] = '{32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 1'b0};
        v[5] = '{32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 1'b0};
        v[6] = '{32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0};
        v[7] = '{32'h41200000, 32'h40000000, 1'b1, 32'h41000000, 1'b0};
        while (rcvd < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== hres || out_tag !== htag) begin
                    failures++;
                    $display("FAIL b2b_stable: got v=%b res=%h tag=%h required v=1 res=%h tag=%h",
                             out_valid, out_res, out_tag, hres, htag);
                end
            end
            out_ready = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1; in_a = v[sent].a; in_b = v[sent].b;
                in_sub = v[sent].sub; in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            ofire = out_valid && out_ready;
            ifire = in_valid && in_ready;
            stall = out_valid && !out_ready;
            hres  = out_res;
            htag  = out_tag;
            if (ofire) begin
                checks++;
                if (out_res !== v[rcvd].r) begin
                    failures++; $display("FAIL b2b_res[%0d]: got %h required %h", rcvd, out_res, v[rcvd].r);
                end
                checks++;
                if (out_tag !== 4'(rcvd)) begin
                    failures++; $display("FAIL b2b_tag[%0d]: got %h required %h", rcvd, out_tag, 4'(rcvd));
                end
                rcvd++;
            end
            @(posedge clk);
            if (ifire) sent++;
        end
        checks++;
        if (rcvd != 8) begin failures++; $display("FAIL b2b_count: got %0d required 8", rcvd); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL b2b_extra: got out_valid=%b tag=%h required 0", out_valid, out_tag);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] r; logic [3:0] rt; logic ov; int lat;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000;
            in_sub = 1'b0; in_tag = 4'(i + 1);
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_res !== 32'h0) begin
            failures++; $display("FAIL midrst_out: got v=%b res=%h required v=0 res=00000000", out_valid, out_res);
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_stale: got out_valid=%b tag=%h required 0", out_valid, out_tag);
            end
        end
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 4'h7, r, rt, ov, lat);
        checks++;
        if (r !== 32'h40000000 || rt !== 4'h7 || lat !== 4) begin
            failures++; $display("FAIL midrst_after: got res=%h tag=%h lat=%0d required res=40000000 tag=7 lat=4", r, rt, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_special_values();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
